// File: rtl/seg_auth_pkg.sv
// Shared types, counter-width helpers and default sizes for the
// password checker and its entry buffer.
package seg_auth_pkg;

  localparam int DIGIT_W_DEF    = 4;
  localparam int NUM_DIGITS_DEF = 6;
  localparam int ADDR_W_DEF     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_FETCH,
    S_COMPARE,
    S_PASSED,
    S_LOCKOUT
  } auth_state_t;

  // Bits needed to hold the values 0..n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/password_checker_if.sv
// Password ROM bus: master drives rom_addr, slave returns rom_data.
// Ports: rom_addr (ADDR_W), rom_data (PW_W).
interface password_checker_if
  import seg_auth_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PW_W   = DIGIT_W_DEF * NUM_DIGITS_DEF
);

  logic [ADDR_W-1:0] rom_addr;
  logic [PW_W-1:0]   rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/password_entry_buffer.sv
// MSB-first digit shift register with digit counter and full flag.
// Ports: clk, rst, i_clr, i_push, i_digit -> o_buf, o_count, o_full.
module password_entry_buffer
  import seg_auth_pkg::*;
#(
  parameter  int DIGIT_W    = DIGIT_W_DEF,
  parameter  int NUM_DIGITS = NUM_DIGITS_DEF,
  localparam int PW_W       = DIGIT_W * NUM_DIGITS,
  localparam int CNT_W      = cnt_w(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [PW_W-1:0]    o_buf,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full
);

  logic [PW_W-1:0]  r_buf;
  logic [CNT_W-1:0] r_count;
  logic [PW_W-1:0]  w_shift;

  assign w_shift = (r_buf << DIGIT_W) | PW_W'(i_digit);
  assign o_full  = (r_count == CNT_W'(NUM_DIGITS));

  // Clear has priority over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_buf   <= w_shift;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_buf   = r_buf;
  assign o_count = r_count;

endmodule

// File: rtl/password_checker.sv
// Session/password stage: collects digits, fetches the stored password
// over a ROM bus, compares, and manages login, attempts and lockout.
// Ports: clk, rst, digit_in/valid, clear_entry, id_matched/is_guest,
// player_addr_in, logout_req, rom (ROM bus master); outputs logged_in,
// logged_out, is_guest, player_addr_out, logout_to_id, locked_out,
// attempts_left, digits_entered.
// Macro PASSWORD_CHECKER_ENTRY_TIMEOUT_EN adds an inactivity timeout
// in ENTRY (parameter ENTRY_TIMEOUT_CYCLES).
module password_checker
  import seg_auth_pkg::*;
#(
  parameter  int DIGIT_W        = DIGIT_W_DEF,
  parameter  int NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter  int ADDR_W         = ADDR_W_DEF,
  parameter  int MAX_ATTEMPTS   = 3,
  parameter  int ROM_LATENCY    = 2,
  parameter  int LOCKOUT_CYCLES = 1000,
`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
  parameter  int ENTRY_TIMEOUT_CYCLES = 50_000_000,
`endif
  localparam int PW_W   = DIGIT_W * NUM_DIGITS,
  localparam int ATT_W  = cnt_w(MAX_ATTEMPTS),
  localparam int DIG_W  = cnt_w(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               clear_entry,
  input  logic               id_matched,
  input  logic               id_is_guest,
  input  logic [ADDR_W-1:0]  player_addr_in,
  input  logic               logout_req,
  password_checker_if.master rom,
  output logic               logged_in,
  output logic               logged_out,
  output logic               is_guest,
  output logic [ADDR_W-1:0]  player_addr_out,
  output logic               logout_to_id,
  output logic               locked_out,
  output logic [ATT_W-1:0]   attempts_left,
  output logic [DIG_W-1:0]   digits_entered
);

  localparam int FCNT_W = cnt_w(ROM_LATENCY);
  localparam int LCNT_W = cnt_w(LOCKOUT_CYCLES);

  auth_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_guest, w_guest_nxt;
  logic [ADDR_W-1:0]  r_rom_addr, w_rom_addr_nxt;
  logic [PW_W-1:0]    r_rom_pw, w_rom_pw_nxt;
  logic [FCNT_W-1:0]  r_fcnt, w_fcnt_nxt;
  logic [LCNT_W-1:0]  r_lcnt, w_lcnt_nxt;
  logic               r_li, w_li_nxt;
  logic               r_lo, w_lo_nxt;
  logic               r_ig, w_ig_nxt;
  logic [ADDR_W-1:0]  r_pa, w_pa_nxt;
  logic               r_lt, w_lt_nxt;
  logic               r_lk, w_lk_nxt;
  logic [ATT_W-1:0]   r_att, w_att_nxt;

  logic               w_buf_clr;
  logic               w_buf_push;
  logic [PW_W-1:0]    w_buf;
  logic [DIG_W-1:0]   w_cnt;
  logic               w_full;

`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
  localparam int TCNT_W = cnt_w(ENTRY_TIMEOUT_CYCLES);
  logic [TCNT_W-1:0]  r_tcnt, w_tcnt_nxt;
`endif

  password_entry_buffer #(
    .DIGIT_W    (DIGIT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_buf_clr),
    .i_push  (w_buf_push),
    .i_digit (digit_in),
    .o_buf   (w_buf),
    .o_count (w_cnt),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_guest_nxt    = r_guest;
    w_rom_addr_nxt = r_rom_addr;
    w_rom_pw_nxt   = r_rom_pw;
    w_fcnt_nxt     = '0;
    w_lcnt_nxt     = '0;
    w_li_nxt       = r_li;
    w_lo_nxt       = r_lo;
    w_ig_nxt       = r_ig;
    w_pa_nxt       = r_pa;
    w_lt_nxt       = 1'b0;
    w_lk_nxt       = r_lk;
    w_att_nxt      = r_att;
    w_buf_clr      = 1'b0;
    w_buf_push     = 1'b0;
`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
    w_tcnt_nxt     = '0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_buf_clr = 1'b1;
        if (id_matched) begin
          w_addr_nxt  = player_addr_in;
          w_guest_nxt = id_is_guest;
          if (id_is_guest) begin
            w_state_nxt = S_PASSED;
            w_li_nxt    = 1'b1;
            w_lo_nxt    = 1'b0;
            w_ig_nxt    = 1'b1;
            w_pa_nxt    = player_addr_in;
          end else begin
            w_state_nxt = S_ENTRY;
          end
        end
      end
      S_ENTRY: begin
        if (clear_entry) begin
          w_buf_clr = 1'b1;
        end else if (digit_valid) begin
          w_buf_push = 1'b1;
          if (w_cnt == DIG_W'(NUM_DIGITS - 1)) begin
            w_state_nxt    = S_FETCH;
            w_rom_addr_nxt = r_addr;
          end
        end
`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
        if (clear_entry || digit_valid) begin
          w_tcnt_nxt = '0;
        end else if (r_tcnt == TCNT_W'(ENTRY_TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_lt_nxt    = 1'b1;
          w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
          w_buf_clr   = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
`endif
      end
      S_FETCH: begin
        // Data for the address issued on entry is valid on the last count.
        w_fcnt_nxt = r_fcnt + FCNT_W'(1);
        if (r_fcnt == FCNT_W'(ROM_LATENCY)) begin
          w_rom_pw_nxt = rom.rom_data;
          w_state_nxt  = S_COMPARE;
          w_fcnt_nxt   = '0;
        end
      end
      S_COMPARE: begin
        w_buf_clr = 1'b1;
        if (w_full && (r_rom_pw == w_buf)) begin
          w_state_nxt = S_PASSED;
          w_li_nxt    = 1'b1;
          w_lo_nxt    = 1'b0;
          w_ig_nxt    = r_guest;
          w_pa_nxt    = r_addr;
          w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
        end else if (r_att > ATT_W'(1)) begin
          w_att_nxt   = r_att - ATT_W'(1);
          w_state_nxt = S_ENTRY;
        end else begin
          w_lt_nxt = 1'b1;
          if (LOCKOUT_CYCLES == 0) begin
            w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
            w_state_nxt = S_IDLE;
          end else begin
            w_att_nxt   = '0;
            w_lk_nxt    = 1'b1;
            w_state_nxt = S_LOCKOUT;
          end
        end
      end
      S_PASSED: begin
        w_buf_clr = 1'b1;
        if (logout_req) begin
          w_li_nxt    = 1'b0;
          w_lo_nxt    = 1'b1;
          w_ig_nxt    = 1'b0;
          w_lt_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        w_buf_clr = 1'b1;
        if (r_lcnt == LCNT_W'(LOCKOUT_CYCLES - 1)) begin
          w_lk_nxt    = 1'b0;
          w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
          w_state_nxt = S_IDLE;
        end else begin
          w_lcnt_nxt = r_lcnt + LCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_guest    <= 1'b0;
      r_rom_addr <= '0;
      r_rom_pw   <= '0;
      r_fcnt     <= '0;
      r_lcnt     <= '0;
      r_li       <= 1'b0;
      r_lo       <= 1'b1;
      r_ig       <= 1'b0;
      r_pa       <= '0;
      r_lt       <= 1'b0;
      r_lk       <= 1'b0;
      r_att      <= ATT_W'(MAX_ATTEMPTS);
`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
      r_tcnt     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_guest    <= w_guest_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_rom_pw   <= w_rom_pw_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_li       <= w_li_nxt;
      r_lo       <= w_lo_nxt;
      r_ig       <= w_ig_nxt;
      r_pa       <= w_pa_nxt;
      r_lt       <= w_lt_nxt;
      r_lk       <= w_lk_nxt;
      r_att      <= w_att_nxt;
`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
      r_tcnt     <= w_tcnt_nxt;
`endif
    end
  end

  assign rom.rom_addr     = r_rom_addr;
  assign logged_in        = r_li;
  assign logged_out       = r_lo;
  assign is_guest         = r_ig;
  assign player_addr_out  = r_pa;
  assign logout_to_id     = r_lt;
  assign locked_out       = r_lk;
  assign attempts_left    = r_att;
  assign digits_entered   = w_cnt;

endmodule

// File: tb/tb_password_checker.sv
// Scoreboard bench for password_checker: scripted and random sessions,
// expected output changes queued with their cycle, checked by a monitor.
module tb_password_checker;

  localparam int DW = 4;
  localparam int ND = 6;
  localparam int AW = 5;
  localparam int MA = 3;
  localparam int RL = 2;
  localparam int LC = 20;
  localparam int TO = 10;
  localparam int PW = DW * ND;

  typedef struct packed {
    logic          li;
    logic          lo;
    logic          g;
    logic [AW-1:0] pa;
    logic          lt;
    logic          lk;
    logic [1:0]    al;
    logic [2:0]    de;
    logic [AW-1:0] ra;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  localparam obs_t RST_OBS = '{li: 1'b0, lo: 1'b1, g: 1'b0, pa: '0,
                               lt: 1'b0, lk: 1'b0, al: 2'd3, de: 3'd0,
                               ra: '0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] digit_in = '0;
  logic          digit_valid = 1'b0;
  logic          clear_entry = 1'b0;
  logic          id_matched = 1'b0;
  logic          id_is_guest = 1'b0;
  logic [AW-1:0] player_addr_in = '0;
  logic          logout_req = 1'b0;
  logic          logged_in, logged_out, is_guest;
  logic [AW-1:0] player_addr_out;
  logic          logout_to_id, locked_out;
  logic [1:0]    attempts_left;
  logic [2:0]    digits_entered;

  password_checker_if #(.ADDR_W(AW), .PW_W(PW)) rom_bus ();

  password_checker #(
    .DIGIT_W        (DW),
    .NUM_DIGITS     (ND),
    .ADDR_W         (AW),
    .MAX_ATTEMPTS   (MA),
    .ROM_LATENCY    (RL),
    .LOCKOUT_CYCLES (LC)
`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
    , .ENTRY_TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .digit_in        (digit_in),
    .digit_valid     (digit_valid),
    .clear_entry     (clear_entry),
    .id_matched      (id_matched),
    .id_is_guest     (id_is_guest),
    .player_addr_in  (player_addr_in),
    .logout_req      (logout_req),
    .rom             (rom_bus),
    .logged_in       (logged_in),
    .logged_out      (logged_out),
    .is_guest        (is_guest),
    .player_addr_out (player_addr_out),
    .logout_to_id    (logout_to_id),
    .locked_out      (locked_out),
    .attempts_left   (attempts_left),
    .digits_entered  (digits_entered)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External synchronous ROM with RL-cycle latency.
  logic [PW-1:0] mem [32];
  logic [PW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem[rom_bus.rom_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_bus.rom_data = pipe[RL-1];

  obs_t w_obs;
  assign w_obs = {logged_in, logged_out, is_guest, player_addr_out,
                  logout_to_id, locked_out, attempts_left,
                  digits_entered, rom_bus.rom_addr};

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  obs_t m, m_last;

  function automatic string fmt(input obs_t o);
    return $sformatf("li=%0b lo=%0b g=%0b pa=%0d lt=%0b lk=%0b al=%0d de=%0d ra=%0d",
                     o.li, o.lo, o.g, o.pa, o.lt, o.lk, o.al, o.de, o.ra);
  endfunction

  function automatic void expect_at(input int c);
    exp_t e;
    if (m !== m_last) begin
      e.cyc = c;
      e.o   = m;
      q.push_back(e);
      m_last = m;
    end
  endfunction

  // Monitor: every observed output change must match the next expectation.
  bit   mon_en = 1'b0;
  obs_t mon_prev;
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && (w_obs !== mon_prev)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got %s", cyc, fmt(w_obs));
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.o !== w_obs) begin
          n_fail++;
          $display("FAIL event cyc=%0d got %s | want cyc=%0d %s",
                   cyc, fmt(w_obs), mon_e.cyc, fmt(mon_e.o));
        end
      end
      mon_prev = w_obs;
    end
  end

  // Reference state kept at the level of the session rules.
  logic [AW-1:0] sess_addr;
  logic [PW-1:0] pw_typed;
  int            n_dig = 0;
  int            att = MA;

  task automatic step();
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    clear_entry = 1'b0;
    id_matched  = 1'b0;
    logout_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic login(input logic [AW-1:0] a, input logic g);
    step();
    id_matched     = 1'b1;
    id_is_guest    = g;
    player_addr_in = a;
    sess_addr      = a;
    if (g) begin
      m.li = 1'b1; m.lo = 1'b0; m.g = 1'b1; m.pa = a;
      expect_at(cyc + 1);
    end
  endtask

  task automatic logout();
    int c;
    step();
    logout_req = 1'b1;
    c = cyc + 1;
    m.li = 1'b0; m.lo = 1'b1; m.g = 1'b0; m.lt = 1'b1;
    expect_at(c);
    m.lt = 1'b0;
    expect_at(c + 1);
  endtask

  task automatic enter_digit(input logic [DW-1:0] d);
    int c, c2;
    step();
    digit_valid = 1'b1;
    digit_in    = d;
    c = cyc + 1;
    pw_typed = {pw_typed[PW-DW-1:0], d};
    n_dig++;
    m.de = 3'(n_dig);
    if (n_dig == ND) begin
      m.ra = sess_addr;
      expect_at(c);
      c2 = c + RL + 2;
      n_dig = 0;
      m.de = '0;
      if (pw_typed == mem[sess_addr]) begin
        m.li = 1'b1; m.lo = 1'b0; m.g = 1'b0; m.pa = sess_addr;
        att = MA; m.al = 2'(att);
        expect_at(c2);
      end else if (att > 1) begin
        att--; m.al = 2'(att);
        expect_at(c2);
      end else begin
        m.al = '0; m.lt = 1'b1; m.lk = 1'b1;
        expect_at(c2);
        m.lt = 1'b0;
        expect_at(c2 + 1);
        att = MA; m.al = 2'(att); m.lk = 1'b0;
        expect_at(c2 + LC);
      end
    end else begin
      expect_at(c);
    end
  endtask

  task automatic enter_pw(input logic [PW-1:0] v);
    logic [PW-1:0] t;
    t = v;
    for (int i = 0; i < ND; i++) enter_digit(t[PW-1-i*DW -: DW]);
  endtask

  function automatic logic [PW-1:0] wrong_pw(input logic [AW-1:0] a);
    logic [PW-1:0] w;
    w = PW'($urandom);
    if (w == mem[a]) w = w ^ PW'(1);
    return w;
  endfunction

  task automatic noise(input bit wide);
    step();
    digit_valid    = 1'b1;
    digit_in       = DW'($urandom);
    clear_entry    = wide;
    id_matched     = wide;
    id_is_guest    = 1'($urandom);
    player_addr_in = AW'($urandom);
    logout_req     = wide;
  endtask

  initial begin
    logic [AW-1:0] a;
    int c;
    for (int i = 0; i < 32; i++) mem[i] = PW'($urandom);
    mem[3] = 24'h1A2B3C;
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    n_tests++;
    if (w_obs !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset got %s want %s", fmt(w_obs), fmt(RST_OBS));
    end
    m = RST_OBS;
    m_last = RST_OBS;
    mon_prev = w_obs;
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // Known password at address 3, stray digit during the fetch.
    login(5'd3, 1'b0);
    enter_pw(24'h1A2B3C);
    noise(1'b0);
    idle(RL + 3);
    logout();
    idle(2);

    // Guest session.
    login(AW'($urandom), 1'b1);
    idle(2);
    logout();
    idle(2);

    // Three failures into lockout, inputs hammered during lockout.
    a = AW'($urandom);
    login(a, 1'b0);
    for (int k = 0; k < MA; k++) begin
      enter_pw(wrong_pw(a));
      idle(RL + 3);
    end
    repeat (5) noise(1'b1);
    idle(LC);
    a = AW'($urandom);
    login(a, 1'b0);
    enter_pw(mem[a]);
    idle(RL + 3);
    logout();
    idle(2);

    // Partial entry, clear wins over a simultaneous digit.
    a = AW'($urandom);
    login(a, 1'b0);
    for (int k = 0; k < 4; k++) enter_digit(DW'($urandom));
    step();
    clear_entry = 1'b1;
    digit_valid = 1'b1;
    digit_in    = DW'($urandom);
    n_dig = 0; m.de = '0;
    expect_at(cyc + 1);
    enter_pw(mem[a]);
    idle(RL + 3);
    logout();
    idle(2);

    // Random sessions.
    for (int s = 0; s < 8; s++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        login(a, 1'b1);
        idle($urandom_range(1, 3));
        logout();
      end else begin
        login(a, 1'b0);
        repeat ($urandom_range(0, MA - 1)) begin
          enter_pw(wrong_pw(a));
          idle(RL + 3);
        end
        enter_pw(mem[a]);
        idle(RL + 3);
        logout();
      end
      idle(2);
    end

    // Reset in the middle of a ROM fetch.
    login(5'd3, 1'b0);
    for (int k = 0; k < ND - 1; k++) enter_digit(DW'(k + 1));
    step();
    digit_valid = 1'b1;
    digit_in    = 4'h7;
    m.de = 3'(ND); m.ra = 5'd3;
    expect_at(cyc + 1);
    step();
    rst = 1'b1;
    m = RST_OBS; att = MA; n_dig = 0;
    expect_at(cyc + 1);
    step();
    rst = 1'b0;
    idle(2);
    login(5'd3, 1'b0);
    enter_pw(24'h1A2B3C);
    idle(RL + 3);
    logout();
    idle(2);

`ifdef PASSWORD_CHECKER_ENTRY_TIMEOUT_EN
    // Inactivity timeout during entry.
    login(AW'($urandom), 1'b0);
    enter_digit(DW'($urandom));
    enter_digit(DW'($urandom));
    c = cyc + 1;
    n_dig = 0;
    m.de = '0; m.lt = 1'b1;
    expect_at(c + TO);
    m.lt = 1'b0;
    expect_at(c + TO + 1);
    idle(TO + 4);
`else
    c = 0;
`endif

    idle(5);
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got %0d left want 0 (next cyc=%0d %s)",
               q.size(), q[0].cyc, fmt(q[0].o));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Parametrised successor to the fixed 6-nibble, 3-attempt password stage.
- Sits between the ID stage and the game controller.
- Collects a NUM_DIGITS-digit password from switch/button pulses, fetches the stored password for the matched player from an external synchronous ROM, and compares the two.
- Manages the session; adds clear-entry, attempts-remaining reporting and a timed lockout after MAX_ATTEMPTS failures.

Parameters:
- DIGIT_W, 4, bits per entered digit
- NUM_DIGITS, 6, digits per password; PW_W = DIGIT_W*NUM_DIGITS
- ADDR_W, 5, player/ROM address width
- MAX_ATTEMPTS, 3, failed compares allowed before lockout (>=1)
- ROM_LATENCY, 2, cycles from rom_addr to valid rom_data (>=1)
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (0 = no hold)

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- digit_in, in, DIGIT_W, switch value
- digit_valid, in, 1, one-cycle debounced button pulse
- clear_entry, in, 1, discard digits typed so far
- id_matched, in, 1, ID stage accepted a user
- id_is_guest, in, 1, matched user is a guest
- player_addr_in, in, ADDR_W, matched player address
- logout_req, in, 1, logout command from game controller
- rom_addr, out, ADDR_W, password ROM address
- rom_data, in, PW_W, stored password
- logged_in, out, 1, session active
- logged_out, out, 1, no session
- is_guest, out, 1, active session is a guest
- player_addr_out, out, ADDR_W, address of logged-in player
- logout_to_id, out, 1, one-cycle pulse telling ID stage to drop user
- locked_out, out, 1, lockout timer running
- attempts_left, out, $clog2(MAX_ATTEMPTS+1), remaining attempts
- digits_entered, out, $clog2(NUM_DIGITS+1), digits accepted in current attempt

Behaviour:
- All outputs registered.
- Reset values: logged_out=1; logged_in=is_guest=logout_to_id=locked_out=0; rom_addr=player_addr_out=0; attempts_left=MAX_ATTEMPTS; digits_entered=0; state IDLE.
- rst takes effect from any state, mid-entry or mid-fetch. Entry buffer and timer are cleared.
- States: IDLE, ENTRY, FETCH, COMPARE, PASSED, LOCKOUT.
- IDLE:
  - On id_matched, latch player_addr_in.
  - If id_is_guest, go to PASSED; otherwise go to ENTRY.
  - logout_to_id=0 by default; it is high for exactly one cycle whenever pulsed.
- ENTRY:
  - digit_valid shifts digit_in into the buffer MSB-first; digits_entered increments.
  - The NUM_DIGITS-th accepted digit moves to FETCH.
  - clear_entry zeroes digits_entered and wins over a same-cycle digit_valid.
- FETCH:
  - rom_addr = latched address; count ROM_LATENCY cycles.
  - Capture rom_data on the last count, then go to COMPARE.
  - digit_valid is ignored.
- COMPARE:
  - Full PW_W equality check.
  - Match: go to PASSED; attempts_left=MAX_ATTEMPTS.
  - Mismatch with attempts_left>1: decrement, digits_entered=0, return to ENTRY.
  - Mismatch with attempts_left==1: attempts_left=0, pulse logout_to_id, go to LOCKOUT.
- Latency: logged_in rises ROM_LATENCY+2 cycles after the cycle the final digit is accepted.
- PASSED:
  - logged_in=1, logged_out=0, is_guest=id_is_guest, player_addr_out=latched address.
  - On logout_req in the same cycle outputs flip: logged_in=0, logged_out=1, is_guest=0. Pulse logout_to_id, go to IDLE.
- LOCKOUT:
  - locked_out=1; all inputs except rst ignored.
  - After LOCKOUT_CYCLES cycles: locked_out=0, attempts_left=MAX_ATTEMPTS, go to IDLE.
  - LOCKOUT_CYCLES=0 skips LOCKOUT; the machine goes straight to IDLE.
- id_matched and logout_req outside their states are ignored.
- Lockout counter is wide enough for LOCKOUT_CYCLES and never wraps.

Optional Feature:
- PASSWORD_CHECKER_ENTRY_TIMEOUT_EN.
- Defined:
  - Adds parameter ENTRY_TIMEOUT_CYCLES (default 50_000_000).
  - The counter restarts on every accepted digit and on clear_entry.
  - If it expires in ENTRY, go to IDLE, pulse logout_to_id and restore attempts_left. The timeout is not counted as a failure.
- Undefined: ENTRY waits indefinitely; no counter logic is synthesised.

Decomposition:
- Package seg_auth_pkg holds:
  - state enum auth_state_t;
  - localparam helpers for attempt/digit counter widths;
  - default constants for DIGIT_W, NUM_DIGITS, ADDR_W.
- One sub-module: password_entry_buffer (shift register plus digit counter, clear, full flag). It is reusable by the ID stage.
- The ROM stays outside the block.

Test Plan:
- Non-guest, ROM[3]=24'h1A2B3C; enter 1,A,2,B,3,C → logged_in=1 exactly ROM_LATENCY+2 cycles after the last pulse; player_addr_out=3; attempts_left=3.
- Guest with id_matched → logged_in the next cycle, is_guest=1, rom_addr never changes; then logout_req → logged_out=1 and one-cycle logout_to_id.
- Three wrong 6-digit entries → attempts_left steps 3→2→1→0; logout_to_id pulse; locked_out=1 for LOCKOUT_CYCLES (set 20); digits during lockout ignored; then IDLE with attempts_left=3.
- Enter 4 digits, clear_entry together with digit_valid → digits_entered=0; a correct 6-digit entry afterwards passes.
- rst asserted mid-FETCH → next cycle logged_out=1, state IDLE, attempts_left=MAX_ATTEMPTS; a fresh id_matched starts cleanly.
- With PASSWORD_CHECKER_ENTRY_TIMEOUT_EN and ENTRY_TIMEOUT_CYCLES=10: enter 2 digits, then idle 10 cycles → IDLE, logout_to_id pulse, attempts_left unchanged at 3.
